// File: rtl/icache_refill_bridge_pkg.sv
// Shared types and constants for the icache refill bridge: memory-side request/response
// structs, the narrow beat bus structs and line geometry.
package icache_refill_bridge_pkg;

   localparam int unsigned PLEN                     = 32;
   localparam int unsigned ICACHE_LINE_WIDTH        = 128;
   localparam int unsigned ICACHE_OFFSET_WIDTH      = $clog2(ICACHE_LINE_WIDTH / 8);
   localparam int unsigned ICACHE_REFILL_BEAT_WIDTH = 32;

   typedef struct packed {
      logic            req;
      logic [PLEN-1:0] paddr;
   } mem_req_t;

   typedef struct packed {
      logic                         ready;
      logic [ICACHE_LINE_WIDTH-1:0] data;
   } mem_rsp_t;

   typedef struct packed {
      logic            req;
      logic [PLEN-1:0] addr;
   } icache_bus_req_t;

   typedef struct packed {
      logic                                gnt;
      logic                                rvalid;
      logic [ICACHE_REFILL_BEAT_WIDTH-1:0] rdata;
   } icache_bus_rsp_t;

   // Clears the byte offset inside a cache line.
   function automatic logic [PLEN-1:0] line_align(input logic [PLEN-1:0] addr);
      return addr & ~PLEN'((ICACHE_LINE_WIDTH / 8) - 1);
   endfunction

endpackage

// File: rtl/icache_refill_bridge_line_assembler.sv
// Collects in-order read beats into one cache line; beat 0 lands in the least-significant bits.
module icache_line_assembler
   import icache_refill_bridge_pkg::*;
#(
   parameter int unsigned BEAT_WIDTH = ICACHE_REFILL_BEAT_WIDTH,
   parameter int unsigned LINE_WIDTH = ICACHE_LINE_WIDTH,
   parameter int unsigned NUM_BEATS  = LINE_WIDTH / BEAT_WIDTH,
   parameter int unsigned CNT_W      = $clog2(NUM_BEATS) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  beat_valid_i,
   input  logic [BEAT_WIDTH-1:0] beat_data_i,
   output logic [CNT_W-1:0]      rsp_cnt_o,
   output logic [LINE_WIDTH-1:0] line_o,
   output logic                  complete_o
);

   logic [CNT_W-1:0]      rsp_cnt_q, rsp_cnt_d;
   logic [LINE_WIDTH-1:0] line_q, line_d;

   always_comb begin
      rsp_cnt_d = rsp_cnt_q;
      line_d    = line_q;
      if (clear_i) begin
         rsp_cnt_d = '0;
      end else if (beat_valid_i) begin
         for (int b = 0; b < NUM_BEATS; b++) begin
            if (rsp_cnt_q == CNT_W'(b)) begin
               line_d[b*BEAT_WIDTH +: BEAT_WIDTH] = beat_data_i;
            end
         end
         rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rsp_cnt_q <= '0;
      end else begin
         rsp_cnt_q <= rsp_cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      line_q <= line_d;
   end

   // line_o already includes this cycle's beat so the top can register the finished line directly.
   assign rsp_cnt_o  = rsp_cnt_q;
   assign line_o     = line_d;
   assign complete_o = beat_valid_i && !clear_i && (rsp_cnt_q == CNT_W'(NUM_BEATS - 1));

endmodule

// File: rtl/icache_refill_bridge.sv
// Splits one icache line refill into in-order narrow read beats on a req/gnt + rvalid bus
// and returns the reassembled line with a single-cycle ready pulse.
module icache_refill_bridge
   import icache_refill_bridge_pkg::*;
#(
   parameter int unsigned BEAT_WIDTH = ICACHE_REFILL_BEAT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  mem_req_t              mem_req_i,
   output mem_rsp_t              mem_rsp_o,
   output logic                  bus_req_o,
   output logic [PLEN-1:0]       bus_addr_o,
   input  logic                  bus_gnt_i,
   input  logic                  bus_rvalid_i,
   input  logic [BEAT_WIDTH-1:0] bus_rdata_i,
   output logic                  busy_o
);

   localparam int unsigned NUM_BEATS  = ICACHE_LINE_WIDTH / BEAT_WIDTH;
   localparam int unsigned BEAT_BYTES = BEAT_WIDTH / 8;
   localparam int unsigned CNT_W      = $clog2(NUM_BEATS) + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]                   state_q, state_d;
   logic [PLEN-1:0]              line_addr_q, line_addr_d;
   logic [CNT_W-1:0]             gnt_cnt_q, gnt_cnt_d;
   icache_bus_req_t              bus_q, bus_d;
   mem_rsp_t                     rsp_q, rsp_d;

   logic                         start;
   logic                         rvalid_ok;
   logic [CNT_W-1:0]             rsp_cnt;
   logic [ICACHE_LINE_WIDTH-1:0] asm_line;
   logic                         asm_complete;

   function automatic logic [PLEN-1:0] beat_addr(input logic [PLEN-1:0] base,
                                                 input logic [CNT_W-1:0] idx);
      return base + PLEN'(idx) * PLEN'(BEAT_BYTES);
   endfunction

   assign start     = (state_q == IDLE) && mem_req_i.req;
   // A beat is only accepted while one is outstanding; stale or stray rvalids are dropped.
   assign rvalid_ok = bus_rvalid_i && ((state_q == ISSUE) || (state_q == WAIT)) &&
                      (rsp_cnt != gnt_cnt_q);

   icache_line_assembler #(
      .BEAT_WIDTH (BEAT_WIDTH),
      .LINE_WIDTH (ICACHE_LINE_WIDTH),
      .NUM_BEATS  (NUM_BEATS),
      .CNT_W      (CNT_W)
   ) i_line_assembler (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (start),
      .beat_valid_i (rvalid_ok),
      .beat_data_i  (bus_rdata_i),
      .rsp_cnt_o    (rsp_cnt),
      .line_o       (asm_line),
      .complete_o   (asm_complete)
   );

   always_comb begin
      state_d     = state_q;
      line_addr_d = line_addr_q;
      gnt_cnt_d   = gnt_cnt_q;
      bus_d       = bus_q;
      rsp_d       = rsp_q;
      rsp_d.ready = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               line_addr_d = line_align(mem_req_i.paddr);
               gnt_cnt_d   = '0;
               bus_d.req   = 1'b1;
               bus_d.addr  = line_align(mem_req_i.paddr);
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (bus_q.req && bus_gnt_i) begin
               gnt_cnt_d = gnt_cnt_q + CNT_W'(1);
               if (gnt_cnt_q == CNT_W'(NUM_BEATS - 1)) begin
                  bus_d.req = 1'b0;
                  state_d   = asm_complete ? DONE : WAIT;
               end else begin
                  bus_d.addr = beat_addr(line_addr_q, gnt_cnt_d);
               end
            end
         end
         WAIT: begin
            if (asm_complete) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if ((state_d == DONE) && (state_q != DONE)) begin
         rsp_d.ready = 1'b1;
         rsp_d.data  = asm_line;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         line_addr_q <= '0;
         gnt_cnt_q   <= '0;
         bus_q       <= '0;
         rsp_q       <= '0;
      end else begin
         state_q     <= state_d;
         line_addr_q <= line_addr_d;
         gnt_cnt_q   <= gnt_cnt_d;
         bus_q       <= bus_d;
         rsp_q       <= rsp_d;
      end
   end

   assign mem_rsp_o  = rsp_q;
   assign bus_req_o  = bus_q.req;
   assign bus_addr_o = bus_q.addr;
   assign busy_o     = (state_q != IDLE);

`ifndef SYNTHESIS
   // Beats still in flight when a refill is aborted by reset are expected, not a protocol error.
   logic abort_q;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         abort_q <= (state_q != IDLE);
      end else if (start) begin
         abort_q <= 1'b0;
      end
      assert (!(rst_ni && !abort_q && bus_rvalid_i && !rvalid_ok))
         else $error("icache_refill_bridge: rvalid with no beat outstanding");
   end
`endif

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed bench for icache_refill_bridge: per-cycle stimulus with hand-derived expectations.
module tb_icache_refill_bridge;
   import icache_refill_bridge_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   mem_req_t        mreq;
   mem_rsp_t        mrsp;
   logic            bus_req;
   logic [PLEN-1:0] bus_addr;
   logic            gnt;
   logic            rvalid;
   logic [31:0]     rdata;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   icache_refill_bridge dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_req_i    (mreq),
      .mem_rsp_o    (mrsp),
      .bus_req_o    (bus_req),
      .bus_addr_o   (bus_addr),
      .bus_gnt_i    (gnt),
      .bus_rvalid_i (rvalid),
      .bus_rdata_i  (rdata),
      .busy_o       (busy)
   );

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mreq = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      adv();
      adv();
      @(negedge clk);
      n_checks++; if (mrsp.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b expected 0", mrsp.ready); end
      n_checks++; if (mrsp.data !== '0) begin n_fail++; $display("FAIL reset_data got %h expected 0", mrsp.data); end
      n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req got %b expected 0", bus_req); end
      n_checks++; if (bus_addr !== '0) begin n_fail++; $display("FAIL reset_bus_addr got %h expected 0", bus_addr); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
      adv();
      rst_n = 1'b1;
      adv();
   endtask

   task automatic test_basic();
      logic [31:0]     beats [4];
      logic [PLEN-1:0] exp_addr;
      int              k = 0;
      beats = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      for (int c = 0; c < 8; c++) begin
         mreq.req = (c < 7); mreq.paddr = 32'h8000_1234;
         gnt = 1'b1; rvalid = (c >= 2 && c <= 5);
         rdata = rvalid ? beats[k] : 32'h0;
         @(negedge clk);
         n_checks++; if (bus_req !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL basic_bus_req c=%0d got %b", c, bus_req); end
         if (c >= 1 && c <= 4) begin
            exp_addr = 32'h8000_1230 + 32'(4 * (c - 1));
            n_checks++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL basic_addr c=%0d got %h expected %h", c, bus_addr, exp_addr); end
         end
         n_checks++; if (mrsp.ready !== (c == 6)) begin n_fail++; $display("FAIL basic_ready c=%0d got %b", c, mrsp.ready); end
         n_checks++; if (busy !== (c >= 1 && c <= 6)) begin n_fail++; $display("FAIL basic_busy c=%0d got %b", c, busy); end
         if (c == 6) begin
            n_checks++; if (mrsp.data !== 128'h44444444_33333333_22222222_11111111) begin n_fail++; $display("FAIL basic_data got %h", mrsp.data); end
         end
         if (rvalid) k++;
         adv();
      end
   endtask

   task automatic test_gnt_stall();
      logic [31:0]     beats [4];
      logic [PLEN-1:0] exp_addr;
      int              k = 0;
      int              grants = 0;
      beats = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3, 32'hD4D4_D4D4};
      for (int c = 0; c < 11; c++) begin
         mreq.req = (c < 10); mreq.paddr = 32'h8000_1234;
         gnt = !(c >= 3 && c <= 5);
         rvalid = (c == 2 || c == 3 || c == 7 || c == 8);
         rdata = rvalid ? beats[k] : 32'h0;
         @(negedge clk);
         n_checks++; if (bus_req !== (c >= 1 && c <= 7)) begin n_fail++; $display("FAIL stall_bus_req c=%0d got %b", c, bus_req); end
         if (c >= 1 && c <= 7) begin
            exp_addr = 32'h8000_1230 + 32'(4 * ((c <= 2) ? (c - 1) : ((c <= 6) ? 2 : 3)));
            n_checks++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL stall_addr c=%0d got %h expected %h", c, bus_addr, exp_addr); end
         end
         n_checks++; if (mrsp.ready !== (c == 9)) begin n_fail++; $display("FAIL stall_ready c=%0d got %b", c, mrsp.ready); end
         n_checks++; if (busy !== (c >= 1 && c <= 9)) begin n_fail++; $display("FAIL stall_busy c=%0d got %b", c, busy); end
         if (c == 9) begin
            n_checks++; if (mrsp.data !== 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1) begin n_fail++; $display("FAIL stall_data got %h", mrsp.data); end
         end
         if (bus_req && gnt) grants++;
         if (rvalid) k++;
         adv();
      end
      n_checks++; if (grants !== 4) begin n_fail++; $display("FAIL stall_grant_count got %0d expected 4", grants); end
   endtask

   task automatic test_late_rsp();
      logic [31:0]     beats [4];
      logic [PLEN-1:0] exp_addr;
      int              k = 0;
      beats = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
      for (int c = 0; c < 18; c++) begin
         mreq.req = (c < 17); mreq.paddr = 32'h0000_2008;
         gnt = 1'b1;
         rvalid = (c == 9 || c == 11 || c == 13 || c == 15);
         rdata = rvalid ? beats[k] : 32'h0;
         @(negedge clk);
         n_checks++; if (bus_req !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL late_bus_req c=%0d got %b", c, bus_req); end
         if (c >= 1 && c <= 4) begin
            exp_addr = 32'h0000_2000 + 32'(4 * (c - 1));
            n_checks++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL late_addr c=%0d got %h expected %h", c, bus_addr, exp_addr); end
         end
         n_checks++; if (mrsp.ready !== (c == 16)) begin n_fail++; $display("FAIL late_ready c=%0d got %b", c, mrsp.ready); end
         n_checks++; if (busy !== (c >= 1 && c <= 16)) begin n_fail++; $display("FAIL late_busy c=%0d got %b", c, busy); end
         if (c == 16) begin
            n_checks++; if (mrsp.data !== 128'h0D0E0F10_090A0B0C_05060708_01020304) begin n_fail++; $display("FAIL late_data got %h", mrsp.data); end
         end
         if (rvalid) k++;
         adv();
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0]     beats [8];
      logic [PLEN-1:0] exp_addr;
      logic [127:0]    exp_data;
      int              k = 0;
      beats = '{32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003,
                32'hBBBB_0000, 32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003};
      for (int c = 0; c < 15; c++) begin
         mreq.req = (c < 14); mreq.paddr = (c < 7) ? 32'h8000_1234 : 32'h0000_0FF0;
         gnt = 1'b1;
         rvalid = (c >= 2 && c <= 5) || (c >= 9 && c <= 12);
         rdata = rvalid ? beats[k] : 32'h0;
         @(negedge clk);
         n_checks++; if (bus_req !== ((c >= 1 && c <= 4) || (c >= 8 && c <= 11))) begin n_fail++; $display("FAIL b2b_bus_req c=%0d got %b", c, bus_req); end
         if ((c >= 1 && c <= 4) || (c >= 8 && c <= 11)) begin
            exp_addr = (c <= 4) ? 32'h8000_1230 + 32'(4 * (c - 1)) : 32'h0000_0FF0 + 32'(4 * (c - 8));
            n_checks++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL b2b_addr c=%0d got %h expected %h", c, bus_addr, exp_addr); end
         end
         n_checks++; if (mrsp.ready !== (c == 6 || c == 13)) begin n_fail++; $display("FAIL b2b_ready c=%0d got %b", c, mrsp.ready); end
         n_checks++; if (busy !== ((c >= 1 && c <= 6) || (c >= 8 && c <= 13))) begin n_fail++; $display("FAIL b2b_busy c=%0d got %b", c, busy); end
         if (c >= 6) begin
            exp_data = (c < 13) ? 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000
                                : 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
            n_checks++; if (mrsp.data !== exp_data) begin n_fail++; $display("FAIL b2b_data c=%0d got %h expected %h", c, mrsp.data, exp_data); end
         end
         if (rvalid) k++;
         adv();
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0]     beats [7];
      logic [PLEN-1:0] exp_addr;
      int              k = 0;
      beats = '{32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002,
                32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003};
      for (int c = 0; c < 15; c++) begin
         rst_n = (c != 3);
         mreq.req = (c <= 3) || (c >= 7 && c <= 13); mreq.paddr = 32'h4000_0044;
         gnt = (c != 3);
         rvalid = (c == 2) || (c == 4) || (c == 5) || (c >= 9 && c <= 12);
         rdata = rvalid ? beats[k] : 32'h0;
         @(negedge clk);
         if (c >= 4 && c <= 6) begin
            n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_bus_req c=%0d got %b expected 0", c, bus_req); end
            n_checks++; if (bus_addr !== '0) begin n_fail++; $display("FAIL rstmid_bus_addr c=%0d got %h expected 0", c, bus_addr); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy c=%0d got %b expected 0", c, busy); end
         end
         if (c >= 4 && c <= 12) begin
            n_checks++; if (mrsp.ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready c=%0d got %b expected 0", c, mrsp.ready); end
            n_checks++; if (mrsp.data !== '0) begin n_fail++; $display("FAIL rstmid_data c=%0d got %h expected 0", c, mrsp.data); end
         end
         if (c >= 8 && c <= 11) begin
            exp_addr = 32'h4000_0040 + 32'(4 * (c - 8));
            n_checks++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL rstmid_addr c=%0d got %h expected %h", c, bus_addr, exp_addr); end
         end
         if (c == 13) begin
            n_checks++; if (mrsp.ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_fresh_ready got %b expected 1", mrsp.ready); end
            n_checks++; if (mrsp.data !== 128'h55550003_55550002_55550001_55550000) begin n_fail++; $display("FAIL rstmid_fresh_data got %h", mrsp.data); end
         end
         if (rvalid) k++;
         adv();
      end
      rst_n = 1'b1;
   endtask

   task automatic test_paddr_change();
      logic [31:0]     beats [4];
      logic [PLEN-1:0] exp_addr;
      int              k = 0;
      beats = '{32'h0100_0000, 32'h0100_0001, 32'h0100_0002, 32'h0100_0003};
      for (int c = 0; c < 8; c++) begin
         mreq.req = (c < 7); mreq.paddr = (c < 1) ? 32'h0000_0100 : 32'h0000_0200;
         gnt = 1'b1; rvalid = (c >= 2 && c <= 5);
         rdata = rvalid ? beats[k] : 32'h0;
         @(negedge clk);
         if (c >= 1 && c <= 4) begin
            exp_addr = 32'h0000_0100 + 32'(4 * (c - 1));
            n_checks++; if (bus_addr !== exp_addr) begin n_fail++; $display("FAIL paddr_addr c=%0d got %h expected %h", c, bus_addr, exp_addr); end
         end
         n_checks++; if (mrsp.ready !== (c == 6)) begin n_fail++; $display("FAIL paddr_ready c=%0d got %b", c, mrsp.ready); end
         if (c == 6) begin
            n_checks++; if (mrsp.data !== 128'h01000003_01000002_01000001_01000000) begin n_fail++; $display("FAIL paddr_data got %h", mrsp.data); end
         end
         if (rvalid) k++;
         adv();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gnt_stall();
      test_late_rsp();
      test_back_to_back();
      test_reset_mid();
      test_paddr_change();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/icache_refill_bridge.md
Name: icache_refill_bridge

Overview:
- Sits directly downstream of the instruction cache, on its miss/refill port.
- Accepts one line-refill request (mem_req_t) from the icache and splits it into NUM_BEATS narrow, in-order read beats on a simple req/gnt + rvalid memory bus.
- Assembles the returned beats into one full ICACHE_LINE_WIDTH line and hands it back to the icache as mem_rsp_t.
- Handles one line at a time. Pipelined beat issue: requests may overlap with responses.

Parameters:
- BEAT_WIDTH, 32, memory bus data width in bits. Must divide ICACHE_LINE_WIDTH (128) exactly.
- NUM_BEATS, ICACHE_LINE_WIDTH/BEAT_WIDTH (4), derived localparam. Beats per line.
- BEAT_BYTES, BEAT_WIDTH/8 (4), derived localparam. Address increment per beat.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- mem_req_i  in  mem_req_t  refill request from the icache (req, paddr)
- mem_rsp_o  out  mem_rsp_t  refill response to the icache (ready pulse, assembled line)
- bus_req_o  out  1  beat read request valid
- bus_addr_o  out  riscv::PLEN  beat byte address
- bus_gnt_i  in  1  beat request accepted this cycle
- bus_rvalid_i  in  1  beat read data valid, in grant order
- bus_rdata_i  in  BEAT_WIDTH  beat read data
- busy_o  out  1  refill in progress (any state other than IDLE)

Behaviour:
- Reset: clk_i edge with rst_ni=0.
  - State goes to IDLE; all counters cleared.
  - mem_rsp_o.ready=0, mem_rsp_o.data='0, bus_req_o=0, bus_addr_o='0, busy_o=0.
  - A reset mid-refill aborts the refill. Responses arriving after reset are dropped.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - When mem_req_i.req=1, capture line_addr = paddr with the low ICACHE_OFFSET_WIDTH bits forced to 0.
  - Clear gnt_cnt and rsp_cnt, then go to ISSUE.
  - bus_req_o rises on the next cycle (1-cycle request-to-bus latency).
- ISSUE:
  - Drive bus_req_o=1 and bus_addr_o = line_addr + gnt_cnt*BEAT_BYTES.
  - On bus_gnt_i=1, gnt_cnt increments and the address advances in the next cycle.
  - After the grant with gnt_cnt=NUM_BEATS-1: bus_req_o=0 next cycle; go to WAIT, or go straight to DONE if all responses are already in.
  - bus_req_o and bus_addr_o hold stable while bus_gnt_i=0.
- Response capture (in ISSUE or WAIT):
  - Each bus_rvalid_i writes bus_rdata_i into line buffer bits [rsp_cnt*BEAT_WIDTH +: BEAT_WIDTH], then rsp_cnt increments.
  - Beat 0 occupies the least-significant bits.
  - rvalid in the same cycle as a gnt is legal, including a gnt of a later beat.
- WAIT: when the rvalid with rsp_cnt=NUM_BEATS-1 arrives, go to DONE.
- DONE:
  - mem_rsp_o.ready=1 for exactly one cycle, with mem_rsp_o.data = the complete line.
  - Next state is IDLE.
  - mem_rsp_o.data holds its value until the next line completes or reset.
- Request rules:
  - The icache holds mem_req_i.req and paddr stable until it sees ready.
  - paddr changes during a refill are ignored (the latched line_addr is used).
  - In the cycle after DONE the bridge is in IDLE and samples req afresh. Back-to-back refills are legal, with a 1-cycle IDLE gap.
- Bus error cases:
  - rvalid while in IDLE or DONE, or with rsp_cnt=gnt_cnt (no beat outstanding), is a protocol error. It is ignored and flagged by a simulation assertion.
  - gnt while bus_req_o=0 is ignored.
- Counter width: $clog2(NUM_BEATS)+1 bits, so a count of NUM_BEATS is representable.
- Address arithmetic: wraps modulo 2^PLEN. The line never crosses a line boundary because it is aligned.
- Minimum refill latency with gnt always 1 and rvalid one cycle after each gnt:
  - req seen at cycle 0; bus_req_o high cycles 1-4; rvalid cycles 2-5; ready pulse cycle 6.

Decomposition:
- Add to ariane_pkg:
  - ICACHE_REFILL_BEAT_WIDTH (default 32), used as the default for BEAT_WIDTH.
  - typedef icache_bus_req_t {req, addr[PLEN]}.
  - typedef icache_bus_rsp_t {gnt, rvalid, rdata[BEAT_WIDTH]}.
  - The flat ports map onto these typedefs.
- mem_req_t and mem_rsp_t are reused unchanged.
- One sub-module is natural: icache_line_assembler. It holds rsp_cnt and writes each beat into the line buffer, with clear/complete outputs.
- The FSM and the issue counter stay in the top level.

Test Plan:
- Basic refill: paddr=0x8000_1234, gnt=1 always, rdata = 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> addrs 0x8000_1230/34/38/3C; ready pulse at cycle 6; data=0x44444444_33333333_22222222_11111111.
- Gnt stalls: gnt=0 for 3 cycles before beat 2 -> bus_addr_o holds 0x...38 while stalled; 4 grants total; ready is one pulse, 3 cycles later than the basic case.
- Late responses: all 4 gnts back-to-back, then rvalid delayed 5 cycles, beats spaced 2 cycles apart -> bus_req_o low after the 4th gnt; state WAIT; ready one cycle after the 4th rvalid; beat order correct.
- Back-to-back: the second req held high the cycle after ready, paddr=0x0000_0FF0 -> IDLE gap of 1 cycle; new addrs 0xFF0, 0xFF4, 0xFF8, 0xFFC; previous data held until the new ready.
- Reset mid-refill: rst_ni=0 after 2 gnts and 1 rvalid; stale rvalids arrive after reset -> all outputs zero, busy_o=0; stale rvalids ignored; a fresh refill completes correctly.
- paddr change mid-refill: paddr switches 0x100 -> 0x200 during ISSUE -> all beats still use line 0x100.
